clk_lock_supervisor: RTL and testbench
======================================

Name: clk_lock_supervisor

Overview:
- Consumes the DCM chain's lock status and drives the DCM chain's reset input (rstRaw side); the return path of the clock generator.
- Sequences DCM reset, waits for lock with timeout and retry, qualifies lock stability, then releases the system reset.
- On lock loss during operation it re-asserts system reset and restarts the sequence.
- Runs on the free-running board oscillator, never on a DCM output.

Parameters:
- RST_CYCLES, 4: cycles dcmRst is held high per attempt; minimum 3, which is the DCM CLKIN reset requirement.
- LOCK_TIMEOUT, 50000: cycles to wait for lock after dcmRst release before retrying (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive locked cycles required before releasing sysRst.
- MAX_RETRIES, 7: consecutive lock timeouts tolerated before entering FAULT; range 1..15.
- CNT_W, 16: width of the shared down-counter; must satisfy 2^CNT_W > max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- clk  in  1  free-running board oscillator (same net as the DCM input clock).
- rst  in  1  asynchronous reset, active-high; restarts the whole sequence.
- clkLocked  in  1  AND of all DCM LOCKED outputs; asynchronous to clk.
- dcmRst  out  1  reset to the first DCM; active-high.
- sysRst  out  1  system reset; active-high; asserted asynchronously, deasserted synchronously to clk.
- ready  out  1  high only in RUN.
- fault  out  1  high in FAULT.
- retryCount  out  4  consecutive timeouts in the current bring-up.
- lossCount  out  8  lock losses seen in RUN since rst; saturates at 255.

Behaviour:
- Reset values while rst=1: state=RESET_DCM, counter=RST_CYCLES-1, dcmRst=1, sysRst=1, ready=0, fault=0, retryCount=0, lossCount=0.
- clkLocked passes through a 2-flop synchronizer, with both flops reset to 0, giving lockS. All decisions use lockS. Input-to-decision latency is 2 cycles.
- One shared down-counter, reloaded on every state entry.
- RESET_DCM: dcmRst=1, sysRst=1.
  - The state lasts exactly RST_CYCLES cycles.
  - Then go to WAIT_LOCK with counter=LOCK_TIMEOUT-1.
- WAIT_LOCK: dcmRst=0, sysRst=1.
  - If lockS=1, go to STABLE with counter=STABLE_CYCLES-1.
  - Else if counter==0 and lockS=0, increment retryCount.
    - If the new value equals MAX_RETRIES, go to FAULT.
    - Otherwise go to RESET_DCM.
  - lockS=1 on the terminal count cycle wins: go to STABLE, no retry.
- STABLE: dcmRst=0, sysRst=1.
  - If lockS=0, go to RESET_DCM. This counts as neither a retry nor a loss.
  - Else if counter==0, go to RUN and clear retryCount.
- RUN: dcmRst=0, sysRst=0, ready=1.
  - sysRst first reads 0 on the first RUN cycle, registered.
  - If lockS=0, go to RESET_DCM and increment lossCount (saturating).
  - sysRst and ready return to 1 and 0 in the same cycle dcmRst returns to 1.
- FAULT: dcmRst=1, sysRst=1, fault=1, ready=0.
  - Terminal state; leave only via rst.
- All outputs are registered; there are no combinational paths from clkLocked to any output.
- rst mid-sequence: immediate return to the reset values from any state, including FAULT and RUN.
- Glitch rule: a lockS low pulse of one cycle in RUN is a loss; no filtering.

Decomposition:
- Shared clock/reset package holds:
  - the state encoding constants: RESET_DCM=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4, 3-bit;
  - the default timing constants, so ClkGen-level wrappers and benches agree.
- One sub-module: sync_2ff, a 1-bit two-flop synchronizer with async active-high reset and a reset value parameter. It is reused elsewhere for other asynchronous status bits.

Test Plan (benches override RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3):
- Normal bring-up: release rst, raise clkLocked 5 cycles after dcmRst falls -> dcmRst high exactly 4 cycles; sysRst falls 2+8+1 cycles after clkLocked rises; ready=1, retryCount=0.
- Timeout retry: clkLocked held 0 for 2 attempts, then raised -> two further 4-cycle dcmRst pulses spaced 20 cycles apart; retryCount reads 1, then 2, then 0 in RUN.
- Fault: clkLocked held 0 -> after the 3rd timeout, fault=1, dcmRst=1, sysRst=1 permanently; assert rst -> fault=0, sequence restarts.
- Lock loss in RUN: drop clkLocked 1 cycle -> 2 cycles later sysRst=1, dcmRst=1, lossCount=1; re-lock -> RUN again. Repeat 260 losses -> lossCount=255.
- Unstable lock: clkLocked rises, then falls after 3 cycles -> back to RESET_DCM; retryCount and lossCount unchanged; sysRst never deasserted.
- Async reset mid-RUN: assert rst between clock edges -> sysRst=1, dcmRst=1, ready=0 before the next clk edge.

Source files
------------

// File: rtl/clk_lock_supervisor_pkg.sv
// clk_lock_supervisor_pkg: state encoding and default timing shared by the clock generator and its benches
package clk_lock_supervisor_pkg;
  typedef enum logic [2:0] {
    RESET_DCM = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } sup_state_e;
  localparam int DEF_RST_CYCLES    = 4;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 7;
  localparam int DEF_CNT_W         = 16;
endpackage

// File: rtl/clk_lock_supervisor_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer for asynchronous status inputs
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end
  assign q = sync_q;
endmodule

// File: rtl/clk_lock_supervisor.sv
// clk_lock_supervisor: sequences DCM reset, qualifies lock and gates the system reset
module clk_lock_supervisor
  import clk_lock_supervisor_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkLocked,
  output logic       dcmRst,
  output logic       sysRst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retryCount,
  output logic [7:0] lossCount
);
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LD  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       MAX_R  = 4'(MAX_RETRIES);
  sup_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             dcm_rst_q, dcm_rst_d, sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d, fault_q, fault_d;
  logic             lock_s;
  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk(clk),
    .rst(rst),
    .d  (clkLocked),
    .q  (lock_s)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      RESET_DCM: if (cnt_q == '0) begin
        state_d = WAIT_LOCK;
        cnt_d   = TO_LD;
      end
      WAIT_LOCK: if (lock_s) begin
        state_d = STABLE;
        cnt_d   = ST_LD;
      end else if (cnt_q == '0) begin
        retry_d = retry_q + 4'd1;
        state_d = (retry_d == MAX_R) ? FAULT : RESET_DCM;
        cnt_d   = RST_LD;
      end
      STABLE: if (!lock_s) begin
        state_d = RESET_DCM;
        cnt_d   = RST_LD;
      end else if (cnt_q == '0) begin
        state_d = RUN;
        retry_d = '0;
      end
      RUN: if (!lock_s) begin
        state_d = RESET_DCM;
        cnt_d   = RST_LD;
        loss_d  = loss_q + 8'(loss_q != 8'hff);
      end
      FAULT: state_d = FAULT;
      default: begin
        state_d = RESET_DCM;
        cnt_d   = RST_LD;
      end
    endcase
    // outputs follow the next state so they change on the same edge as the state
    dcm_rst_d = (state_d == RESET_DCM) || (state_d == FAULT);
    sys_rst_d = state_d != RUN;
    ready_d   = state_d == RUN;
    fault_d   = state_d == FAULT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_DCM;
      cnt_q     <= RST_LD;
      retry_q   <= '0;
      loss_q    <= '0;
      dcm_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      dcm_rst_q <= dcm_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end
  assign dcmRst     = dcm_rst_q;
  assign sysRst     = sys_rst_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign retryCount = retry_q;
  assign lossCount  = loss_q;
endmodule

// File: tb/tb_clk_lock_supervisor.sv
// tb_clk_lock_supervisor: directed bring-up, retry, fault, loss and reset scenarios
module tb_clk_lock_supervisor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clkLocked = 1'b0;
  logic       dcmRst, sysRst, ready, fault;
  logic [3:0] retryCount;
  logic [7:0] lossCount;
  int checks = 0;
  int errors = 0;

  clk_lock_supervisor #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(3), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .clkLocked(clkLocked),
    .dcmRst(dcmRst), .sysRst(sysRst), .ready(ready), .fault(fault),
    .retryCount(retryCount), .lossCount(lossCount)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, {7'd0, obs}, {7'd0, exp});
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chkb("ready_within_budget", ready, 1'b1);
  endtask

  initial begin
    tick(2);
    chkb("rst_dcmRst", dcmRst, 1'b1);
    chkb("rst_sysRst", sysRst, 1'b1);
    chkb("rst_ready", ready, 1'b0);
    chkb("rst_fault", fault, 1'b0);
    chk("rst_retry", {4'd0, retryCount}, 8'd0);
    chk("rst_loss", lossCount, 8'd0);

    // normal bring-up: dcmRst high for exactly 4 cycles
    rst = 1'b0;
    tick(3);
    chkb("bu_dcm_hi", dcmRst, 1'b1);
    tick();
    chkb("bu_dcm_lo", dcmRst, 1'b0);
    chkb("bu_sys_hi", sysRst, 1'b1);
    tick(5);
    clkLocked = 1'b1;
    tick(10);
    chkb("bu_sys_still_hi", sysRst, 1'b1);
    chkb("bu_not_ready", ready, 1'b0);
    tick();
    chkb("bu_sys_lo", sysRst, 1'b0);
    chkb("bu_ready", ready, 1'b1);
    chkb("bu_dcm_run", dcmRst, 1'b0);
    chk("bu_retry", {4'd0, retryCount}, 8'd0);

    // single-cycle lock loss in RUN
    clkLocked = 1'b0;
    tick();
    clkLocked = 1'b1;
    tick();
    chkb("loss_sys_lo_yet", sysRst, 1'b0);
    tick();
    chkb("loss_sys_hi", sysRst, 1'b1);
    chkb("loss_dcm_hi", dcmRst, 1'b1);
    chkb("loss_ready_lo", ready, 1'b0);
    chk("loss_count1", lossCount, 8'd1);
    tick(12);
    chkb("relock_not_yet", ready, 1'b0);
    tick();
    chkb("relock_ready", ready, 1'b1);
    for (int i = 0; i < 259; i++) begin
      clkLocked = 1'b0;
      tick();
      clkLocked = 1'b1;
      tick(2);
      wait_ready(40);
    end
    chk("loss_count_255", lossCount, 8'd255);

    // one more loss (saturates) then an unstable lock
    clkLocked = 1'b0;
    tick(3);
    chk("loss_saturated", lossCount, 8'd255);
    chkb("loss261_dcm", dcmRst, 1'b1);
    tick(4);
    chkb("unst_wait_dcm", dcmRst, 1'b0);
    clkLocked = 1'b1;
    tick(3);
    chkb("unst_sys_hi_a", sysRst, 1'b1);
    clkLocked = 1'b0;
    tick(2);
    chkb("unst_dcm_lo", dcmRst, 1'b0);
    chkb("unst_sys_hi_b", sysRst, 1'b1);
    tick();
    chkb("unst_dcm_hi", dcmRst, 1'b1);
    chkb("unst_sys_hi_c", sysRst, 1'b1);
    chk("unst_retry", {4'd0, retryCount}, 8'd0);
    chk("unst_loss", lossCount, 8'd255);

    // async reset between edges while in RUN
    clkLocked = 1'b1;
    wait_ready(40);
    #3 rst = 1'b1;
    #1;
    chkb("arst_sys", sysRst, 1'b1);
    chkb("arst_dcm", dcmRst, 1'b1);
    chkb("arst_ready", ready, 1'b0);
    chk("arst_loss", lossCount, 8'd0);
    clkLocked = 1'b0;
    tick(2);

    // two timeouts, then lock
    rst = 1'b0;
    tick(4);
    chkb("to_wait1_dcm", dcmRst, 1'b0);
    tick(19);
    chkb("to_wait1_end", dcmRst, 1'b0);
    chk("to_retry0", {4'd0, retryCount}, 8'd0);
    tick();
    chkb("to_pulse2", dcmRst, 1'b1);
    chk("to_retry1", {4'd0, retryCount}, 8'd1);
    tick(4);
    chkb("to_wait2_dcm", dcmRst, 1'b0);
    tick(19);
    chkb("to_wait2_end", dcmRst, 1'b0);
    tick();
    chkb("to_pulse3", dcmRst, 1'b1);
    chk("to_retry2", {4'd0, retryCount}, 8'd2);
    clkLocked = 1'b1;
    wait_ready(40);
    chk("to_retry_cleared", {4'd0, retryCount}, 8'd0);
    chkb("to_sys_lo", sysRst, 1'b0);

    // three timeouts -> FAULT
    rst = 1'b1;
    clkLocked = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(71);
    chkb("flt_not_yet", fault, 1'b0);
    chkb("flt_wait_dcm", dcmRst, 1'b0);
    tick();
    chkb("flt_fault", fault, 1'b1);
    chkb("flt_dcm", dcmRst, 1'b1);
    chkb("flt_sys", sysRst, 1'b1);
    chkb("flt_ready", ready, 1'b0);
    chk("flt_retry", {4'd0, retryCount}, 8'd3);
    clkLocked = 1'b1;
    tick(30);
    chkb("flt_sticky", fault, 1'b1);
    chkb("flt_sticky_dcm", dcmRst, 1'b1);
    chkb("flt_sticky_sys", sysRst, 1'b1);
    #3 rst = 1'b1;
    #1;
    chkb("flt_rst_clear", fault, 1'b0);
    chk("flt_rst_retry", {4'd0, retryCount}, 8'd0);
    tick();
    rst = 1'b0;
    tick(3);
    chkb("restart_dcm_hi", dcmRst, 1'b1);
    tick();
    chkb("restart_dcm_lo", dcmRst, 1'b0);
    wait_ready(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
